recv_queue: RTL

RECV_QUEUE -- requirements
Module: recv_queue

---
 rtl/recv_queue_pkg.sv | 22 ++
 rtl/recv_queue_if.sv | 25 ++
 rtl/recv_queue_mem.sv | 33 +++
 rtl/recv_queue.sv | 92 +++++++++
 4 files changed

// File: rtl/recv_queue_pkg.sv
// recv_queue_pkg -- shared definitions for the receive queue.
//   clog2()  : pointer-width helper, usable in constant expressions
//   status_t : packed status flags (full, empty, afull)
package recv_queue_pkg;

    // Returns the number of bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
    } status_t;

endpackage

// File: rtl/recv_queue_if.sv
// recv_queue_if -- valid/ready handshake bundle for the receive queue.
//   in_valid/in_ready/in_data    : producer -> queue
//   out_valid/out_ready/out_data : queue -> consumer
//   master : the side driving data in and taking data out (producer/consumer)
//   slave  : the queue itself
interface recv_queue_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/recv_queue_mem.sv
// recv_queue_mem -- storage array for the receive queue.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data, mem[raddr]
module recv_queue_mem
    import recv_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and
    // count, so stale contents are never presented as valid data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fall-through read: the head word is visible without a read strobe.
    assign rdata = mem[raddr];
endmodule

// File: rtl/recv_queue.sv
// recv_queue -- first-word fall-through receive queue.
//   clk      : clock, all state changes on posedge
//   rst      : asynchronous active-low reset
//   flush    : synchronous clear, overrides push and pop
//   bus      : valid/ready handshake (slave modport)
//   count    : current occupancy, 0..DEPTH
//   qfull    : count == DEPTH
//   qempty   : count == 0
//   afull    : count >= AFULL_LVL
//   overflow : one-cycle pulse after a push attempt while full
module recv_queue
    import recv_queue_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    recv_queue_if.slave             bus,
    output logic [clog2(DEPTH):0]   count,
    output logic                    qfull,
    output logic                    qempty,
    output logic                    afull,
    output logic                    overflow
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    status_t          flags;
    logic             push;
    logic             pop;

    // Flags come straight from the count register, so the handshake
    // outputs never depend combinationally on the handshake inputs.
    assign flags.full  = (count == CNT_W'(DEPTH));
    assign flags.empty = (count == '0);
    assign flags.afull = (count >= CNT_W'(AFULL_LVL));

    assign qfull         = flags.full;
    assign qempty        = flags.empty;
    assign afull         = flags.afull;
    assign bus.in_ready  = !flags.full;
    assign bus.out_valid = !flags.empty;

    // No bypass: a full queue rejects a push even when a pop frees a slot,
    // and an empty queue cannot pop the word being pushed.
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= bus.in_valid && !bus.in_ready;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (push) head <= head + PTR_W'(1);
                if (pop)  tail <= tail + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    recv_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (head),
        .wdata (bus.in_data),
        .raddr (tail),
        .rdata (bus.out_data)
    );
endmodule
